pump_duty_sequencer: RTL and testbench

Sits between the filter control FSM and the two pump PWM generators. It turns the FSM's raw duty-cycle targets into slew-limited duty values. It enforces a shared combined-power budget, with pump A having priority, and a minimum off-time after every stop. On a dry (reservoir-empty) condition it forces both pumps off and latches a fault.

---
 rtl/pump_ctrl_pkg.sv | 23 ++
 rtl/pump_ramp_channel.sv | 119 +++++++++++
 rtl/pump_duty_sequencer.sv | 131 +++++++++++++
 tb/tb_pump_duty_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pump_ctrl_pkg.sv
// Shared types for the pump duty sequencer.
//   pump_state_t : per-channel ramp state
//   duty_t       : duty value at the default width
//   is_busy()    : states during which a channel reports busy
package pump_ctrl_pkg;

  localparam int unsigned DEFAULT_DUTY_WIDTH = 8;

  typedef logic [DEFAULT_DUTY_WIDTH-1:0] duty_t;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLDOFF   = 3'd4
  } pump_state_t;

  function automatic logic is_busy(input pump_state_t s);
    return (s == RAMP_UP) || (s == RAMP_DOWN) || (s == HOLDOFF);
  endfunction

endpackage

// File: rtl/pump_ramp_channel.sv
// One slew-limited pump duty channel with post-stop holdoff.
// Ports:
//   clk, reset     : clock, synchronous active-low reset
//   tick_i         : ramp update strobe
//   force_off_i    : dry condition, zero the output on the next edge
//   eff_i          : arbitrated duty target
//   headroom_i     : largest duty this channel may reach on this tick
//   cur_o          : registered duty value
//   cur_d_o        : value cur_o takes on the next edge (feeds the headroom chain)
//   state_o        : current pump_state_t encoding
//   busy_o         : registered busy flag
module pump_ramp_channel
  import pump_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH = DEFAULT_DUTY_WIDTH,
  parameter int unsigned STEP       = 4,
  parameter int unsigned DEAD_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic                  force_off_i,
  input  logic [DUTY_WIDTH-1:0] eff_i,
  input  logic [DUTY_WIDTH:0]   headroom_i,
  output logic [DUTY_WIDTH-1:0] cur_o,
  output logic [DUTY_WIDTH-1:0] cur_d_o,
  output logic [2:0]            state_o,
  output logic                  busy_o
);

  localparam int unsigned DW  = DUTY_WIDTH;
  localparam int unsigned DW1 = DUTY_WIDTH + 1;
  localparam int unsigned HW  = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((DEAD_TICKS == 0) ? 0 : DEAD_TICKS - 1);

  logic [DW-1:0] cur_q;
  logic [DW-1:0] cur_d;
  logic [DW-1:0] step_val;
  logic [DW:0]   up_lim;
  pump_state_t   state_q;
  pump_state_t   step_state;
  logic [HW-1:0] hold_q;
  logic          busy_q;

  // Candidate duty after one step toward eff, clamped by headroom when rising.
  always_comb begin
    step_val = cur_q;
    up_lim   = DW1'(cur_q) + DW1'(STEP);
    if (cur_q > eff_i) begin
      if (DW1'(cur_q) > DW1'(eff_i) + DW1'(STEP)) step_val = cur_q - DW'(STEP);
      else                                         step_val = eff_i;
    end else if (cur_q < eff_i) begin
      if (DW1'(eff_i) < up_lim) up_lim = DW1'(eff_i);
      if (headroom_i < up_lim)  up_lim = headroom_i;
      step_val = DW'(up_lim);
    end
  end

  // State the channel lands in after taking step_val (outside HOLDOFF).
  always_comb begin
    if ((cur_q != '0) && (step_val == '0))
      step_state = (DEAD_TICKS == 0) ? OFF : HOLDOFF;
    else if (step_val == eff_i)
      step_state = (step_val == '0) ? OFF : RUN;
    else if (step_val < eff_i)
      step_state = RAMP_UP;
    else
      step_state = RAMP_DOWN;
  end

  // Next duty: dry wins, then tick; HOLDOFF pins the output at zero.
  always_comb begin
    cur_d = cur_q;
    if (force_off_i)  cur_d = '0;
    else if (tick_i)  cur_d = (state_q == HOLDOFF) ? '0 : step_val;
  end

  // Channel FSM with registered duty, busy and holdoff count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_q   <= '0;
      state_q <= OFF;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      cur_q <= cur_d;
      if (force_off_i) begin
        // A running channel is stopped abruptly, so it still owes its dead time.
        if ((cur_q != '0) && (DEAD_TICKS != 0)) begin
          state_q <= HOLDOFF;
          hold_q  <= '0;
          busy_q  <= 1'b1;
        end else if (state_q != HOLDOFF) begin
          state_q <= OFF;
          busy_q  <= 1'b0;
        end
      end else if (tick_i) begin
        if (state_q == HOLDOFF) begin
          if (hold_q == HOLD_LAST) begin
            state_q <= OFF;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end else begin
          state_q <= step_state;
          busy_q  <= is_busy(step_state);
          if (step_state == HOLDOFF) hold_q <= '0;
        end
      end
    end
  end

  assign cur_o   = cur_q;
  assign cur_d_o = cur_d;
  assign state_o = state_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/pump_duty_sequencer.sv
// Turns raw pump duty targets into slew-limited duties under a shared budget
// (pump A has priority), with post-stop holdoff and a sticky dry fault.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   enable               : 0 ramps both pumps down to 0
//   tgt_a, tgt_b         : requested duties
//   dry_in               : reservoir empty (already synchronised)
//   duty_a_out/duty_b_out: duties to the PWM generators
//   busy                 : a channel is ramping or in holdoff
//   fault_dry            : sticky dry fault
module pump_duty_sequencer
  import pump_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH = DEFAULT_DUTY_WIDTH,
  parameter int unsigned STEP       = 4,
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned BUDGET     = 384,
  parameter int unsigned DEAD_TICKS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] tgt_a,
  input  logic [DUTY_WIDTH-1:0] tgt_b,
  input  logic                  dry_in,
  output logic [DUTY_WIDTH-1:0] duty_a_out,
  output logic [DUTY_WIDTH-1:0] duty_b_out,
  output logic                  busy,
  output logic                  fault_dry
);

  localparam int unsigned DW  = DUTY_WIDTH;
  localparam int unsigned DW1 = DUTY_WIDTH + 1;
  localparam int unsigned CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW:0]   BUDGET_W  = DW1'(BUDGET);

  logic [CW-1:0] cnt_q;
  logic          tick;
  logic [DW-1:0] ta, tb;
  logic [DW-1:0] eff_a, eff_b;
  logic [DW:0]   rem_b;
  logic [DW:0]   headroom_a, headroom_b;
  logic [DW-1:0] cur_d_a, cur_d_b;
  logic [2:0]    st_a, st_b;
  logic          busy_a, busy_b;
  logic          fault_q;

  // Ramp tick generator.
  always_ff @(posedge clk) begin
    if (!reset)    cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

  assign tick = (cnt_q == TICK_LAST);

  // Budget arbitration: A takes what it asks for, B gets the remainder.
  always_comb begin
    ta    = enable ? tgt_a : '0;
    tb    = enable ? tgt_b : '0;
    eff_a = '0;
    eff_b = '0;
    rem_b = '0;
    if (!fault_q) begin
      eff_a = (DW1'(ta) < BUDGET_W) ? ta : DW'(BUDGET_W);
      rem_b = BUDGET_W - DW1'(eff_a);
      eff_b = (DW1'(tb) < rem_b) ? tb : DW'(rem_b);
    end
  end

  // A sees B's current duty; B sees A's post-tick duty, so the sum never overshoots.
  assign headroom_a = BUDGET_W - DW1'(duty_b_out);
  assign headroom_b = BUDGET_W - DW1'(cur_d_a);

  pump_ramp_channel #(
    .DUTY_WIDTH (DUTY_WIDTH),
    .STEP       (STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_chan_a (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (tick),
    .force_off_i (dry_in),
    .eff_i       (eff_a),
    .headroom_i  (headroom_a),
    .cur_o       (duty_a_out),
    .cur_d_o     (cur_d_a),
    .state_o     (st_a),
    .busy_o      (busy_a)
  );

  pump_ramp_channel #(
    .DUTY_WIDTH (DUTY_WIDTH),
    .STEP       (STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_chan_b (
    .clk         (clk),
    .reset       (reset),
    .tick_i      (tick),
    .force_off_i (dry_in),
    .eff_i       (eff_b),
    .headroom_i  (headroom_b),
    .cur_o       (duty_b_out),
    .cur_d_o     (cur_d_b),
    .state_o     (st_b),
    .busy_o      (busy_b)
  );

  // Dry fault latch: clears only once the sensor is wet and both requests are zero.
  always_ff @(posedge clk) begin
    if (!reset)                               fault_q <= 1'b0;
    else if (dry_in)                          fault_q <= 1'b1;
    else if ((ta == '0) && (tb == '0))        fault_q <= 1'b0;
  end

  assign fault_dry = fault_q;
  assign busy      = busy_a | busy_b;

  // Design invariants: budget is never exceeded, idle channels drive zero,
  // and the next-state duty chain respects the budget too.
  a_budget : assert property (@(posedge clk) disable iff (!reset)
    (DW1'(duty_a_out) + DW1'(duty_b_out)) <= BUDGET_W);
  a_next_budget : assert property (@(posedge clk) disable iff (!reset)
    (DW1'(cur_d_a) + DW1'(cur_d_b)) <= BUDGET_W);
  a_idle_a : assert property (@(posedge clk) disable iff (!reset)
    ((st_a == 3'(OFF)) || (st_a == 3'(HOLDOFF))) |-> (duty_a_out == '0));
  a_idle_b : assert property (@(posedge clk) disable iff (!reset)
    ((st_b == 3'(OFF)) || (st_b == 3'(HOLDOFF))) |-> (duty_b_out == '0));

endmodule

// File: tb/tb_pump_duty_sequencer.sv
// Directed bench for pump_duty_sequencer: vector table plus hand sequences
// for dry fault and reset mid-ramp. TICK_DIV=4, STEP=16, BUDGET=300, DEAD_TICKS=2.
module tb_pump_duty_sequencer;
  import pump_ctrl_pkg::*;

  localparam int TB_TICK   = 4;
  localparam int TB_BUDGET = 300;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  enable = 1'b0;
  duty_t tgt_a = '0;
  duty_t tgt_b = '0;
  logic  dry_in = 1'b0;
  duty_t duty_a_out, duty_b_out;
  logic  busy, fault_dry;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit    rst;
    bit    en;
    duty_t ta;
    duty_t tb;
    int    ticks;
    int    ea;
    int    eb;
    int    ebusy;
    int    efault;
    string name;
  } vec_t;

  vec_t vecs[$];

  pump_duty_sequencer #(
    .DUTY_WIDTH (8),
    .STEP       (16),
    .TICK_DIV   (4),
    .BUDGET     (300),
    .DEAD_TICKS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tgt_a      (tgt_a),
    .tgt_b      (tgt_b),
    .dry_in     (dry_in),
    .duty_a_out (duty_a_out),
    .duty_b_out (duty_b_out),
    .busy       (busy),
    .fault_dry  (fault_dry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge; budget checked every cycle.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tests++;
      if (int'(duty_a_out) + int'(duty_b_out) > TB_BUDGET) begin
        fails++;
        $display("FAIL budget_sum at %0t: got %0d expected <= %0d", $time,
                 int'(duty_a_out) + int'(duty_b_out), TB_BUDGET);
      end
    end
  endtask

  task automatic check_outs(input string nm, input int ea, input int eb,
                            input int ebusy, input int efault);
    chk({nm, "_a"}, int'(duty_a_out), ea);
    chk({nm, "_b"}, int'(duty_b_out), eb);
    chk({nm, "_busy"}, int'(busy), ebusy);
    chk({nm, "_fault"}, int'(fault_dry), efault);
  endtask

  task automatic apply_reset();
    enable = 1'b0;
    tgt_a  = '0;
    tgt_b  = '0;
    dry_in = 1'b0;
    reset  = 1'b0;
    cyc(1);
    reset  = 1'b1;
  endtask

  function automatic void add(input int rst, input int en, input int ta, input int tb,
                              input int ticks, input int ea, input int eb,
                              input int ebusy, input int efault, input string name);
    vec_t v;
    v.rst = (rst != 0);
    v.en = (en != 0);
    v.ta = duty_t'(ta);
    v.tb = duty_t'(tb);
    v.ticks = ticks;
    v.ea = ea;
    v.eb = eb;
    v.ebusy = ebusy;
    v.efault = efault;
    v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  rst en  ta   tb  ticks  a    b  busy fault
    add(1, 0,   0,   0,  0,     0,   0, 0, 0, "reset");
    add(0, 1, 200,   0,  1,    16,   0, 1, 0, "ramp_t1");
    add(0, 1, 200,   0,  5,    96,   0, 1, 0, "ramp_t6");
    add(0, 1, 200,   0,  6,   192,   0, 1, 0, "ramp_t12");
    add(0, 1, 200,   0,  1,   200,   0, 0, 0, "ramp_run");
    add(0, 1, 200, 200,  1,   200,  16, 1, 0, "budget_t1");
    add(0, 1, 200, 200,  6,   200, 100, 0, 0, "budget_settle");
    add(0, 1,   0, 250,  1,   184, 116, 1, 0, "handover_t1");
    add(0, 1,   0, 250,  9,    40, 250, 1, 0, "handover_t10");
    add(0, 1,   0, 250,  3,     0, 250, 1, 0, "handover_holdoff");
    add(0, 1,   0, 250,  2,     0, 250, 0, 0, "handover_done");
    add(1, 0,   0,   0,  0,     0,   0, 0, 0, "reset2");
    add(0, 1,  64,   0,  4,    64,   0, 0, 0, "hold_run");
    add(0, 1,   0,   0,  4,     0,   0, 1, 0, "hold_enter");
    add(0, 1,  64,   0,  1,     0,   0, 1, 0, "hold_wait1");
    add(0, 1,  64,   0,  1,     0,   0, 0, 0, "hold_off");
    add(0, 1,  64,   0,  1,    16,   0, 1, 0, "hold_restart");
    add(0, 1,  64,   0,  3,    64,   0, 0, 0, "hold_run2");
    add(0, 0,  64,   0,  1,    48,   0, 1, 0, "enable_low");
    add(0, 0,  64,   0,  3,     0,   0, 1, 0, "enable_zero");

    // Inputs change in the cycle right after a tick, so each tick sees them.
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        apply_reset();
      end else begin
        enable = vecs[i].en;
        tgt_a  = vecs[i].ta;
        tgt_b  = vecs[i].tb;
        cyc(TB_TICK * vecs[i].ticks);
      end
      check_outs(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ebusy, vecs[i].efault);
    end

    // Dry fault mid-ramp: one-cycle kill, sticky until targets drop to zero.
    apply_reset();
    enable = 1'b1;
    tgt_a  = 8'd200;
    cyc(TB_TICK * 3);
    check_outs("dry_pre", 48, 0, 1, 0);
    dry_in = 1'b1;
    cyc(1);
    check_outs("dry_hit", 0, 0, 1, 1);
    dry_in = 1'b0;
    cyc(1);
    check_outs("dry_release", 0, 0, 1, 1);
    cyc(TB_TICK * 3);
    check_outs("dry_latched", 0, 0, 0, 1);
    tgt_a = '0;
    cyc(1);
    check_outs("dry_clear", 0, 0, 0, 0);

    // Reset mid-ramp: immediate zero, tick counter restarts.
    apply_reset();
    enable = 1'b1;
    tgt_a  = 8'd200;
    cyc(TB_TICK * 6);
    check_outs("rst_pre", 96, 0, 1, 0);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    check_outs("rst_hit", 0, 0, 0, 0);
    cyc(TB_TICK - 1);
    check_outs("rst_notick", 0, 0, 0, 0);
    cyc(1);
    check_outs("rst_first_tick", 16, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
